// File: rtl/lsu_mem_arbiter.sv
// lsu_mem_arbiter
// Shares the single data-memory port between load issue and store commit.
// Loads have priority; a store that has waited through STARVE_LIM load grants
// wins the next free slot. An in-order tag FIFO tracks outstanding loads so
// each memory response is returned to the load queue with its ROB tag, and a
// flush marks every in-flight load so its response is dropped silently.
//
// Build option: define LSU_RAW_ORDER_EN to give a store priority over a load
// that targets the same data word in the same cycle.
module lsu_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int ROB_W      = 6,
  parameter int MAX_OUTST  = 4,
  parameter int STARVE_LIM = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       ld_req_valid,
  output logic                       ld_req_ready,
  input  logic [ADDR_W-1:0]          ld_req_addr,
  input  logic [ROB_W-1:0]           ld_req_rob,
  input  logic                       st_req_valid,
  output logic                       st_req_ready,
  input  logic [ADDR_W-1:0]          st_req_addr,
  input  logic [DATA_W-1:0]          st_req_data,
  input  logic [DATA_W/8-1:0]        st_req_be,
  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic                       mem_req_we,
  output logic [ADDR_W-1:0]          mem_req_addr,
  output logic [DATA_W-1:0]          mem_req_wdata,
  output logic [DATA_W/8-1:0]        mem_req_be,
  input  logic                       mem_resp_valid,
  input  logic [DATA_W-1:0]          mem_resp_data,
  output logic                       ld_resp_valid,
  output logic [ROB_W-1:0]           ld_resp_rob,
  output logic [DATA_W-1:0]          ld_resp_data,
  output logic [$clog2(MAX_OUTST):0] outst_cnt,
  output logic                       err_unexp_resp
);

  localparam int BE_W  = DATA_W / 8;
  localparam int PTR_W = $clog2(MAX_OUTST);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_LIM + 1);

  // Request slot register
  logic                 mem_req_valid_r;
  logic                 mem_req_we_r;
  logic [ADDR_W-1:0]    mem_req_addr_r;
  logic [DATA_W-1:0]    mem_req_wdata_r;
  logic [BE_W-1:0]      mem_req_be_r;

  // Arbitration and tag FIFO state
  logic [SC_W-1:0]      starve_cnt_r;
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [CNT_W-1:0]     outst_cnt_r;
  logic                 err_unexp_r;
  logic [MAX_OUTST-1:0] drop_r;
  logic [ROB_W-1:0]     rob_mem_r [MAX_OUTST];

  logic slot_free_s;
  logic load_ok_s;
  logic starve_hit_s;
  logic raw_hit_s;
  logic ld_grant_s;
  logic st_grant_s;
  logic fifo_empty_s;
  logic pop_s;

`ifdef LSU_RAW_ORDER_EN
  localparam int OFF_W = $clog2(BE_W);
  // A store to the word a load is about to read must reach memory first
  assign raw_hit_s = ld_req_valid && st_req_valid &&
                     (ld_req_addr[ADDR_W-1:OFF_W] == st_req_addr[ADDR_W-1:OFF_W]);
`else
  assign raw_hit_s = 1'b0;
`endif

  assign fifo_empty_s = (outst_cnt_r == {CNT_W{1'b0}});
  assign pop_s        = mem_resp_valid && !fifo_empty_s;
  assign starve_hit_s = (starve_cnt_r == SC_W'(STARVE_LIM));

  // Pick at most one winner for the request slot; the count used is the registered one
  always_comb begin
    slot_free_s = !mem_req_valid_r || mem_req_ready;
    load_ok_s   = ld_req_valid && (outst_cnt_r < CNT_W'(MAX_OUTST)) && !flush;
    ld_grant_s  = 1'b0;
    st_grant_s  = 1'b0;
    if (slot_free_s) begin
      if (st_req_valid && (!load_ok_s || starve_hit_s || raw_hit_s)) begin
        st_grant_s = 1'b1;
      end else if (load_ok_s) begin
        ld_grant_s = 1'b1;
      end else begin
        ld_grant_s = 1'b0;
        st_grant_s = 1'b0;
      end
    end else begin
      ld_grant_s = 1'b0;
      st_grant_s = 1'b0;
    end
  end

  assign ld_req_ready = ld_grant_s;
  assign st_req_ready = st_grant_s;

  // Count load grants that overtake a waiting store; any store grant or idle store clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_r <= {SC_W{1'b0}};
    end else if (!st_req_valid || st_grant_s) begin
      starve_cnt_r <= {SC_W{1'b0}};
    end else if (ld_grant_s && !starve_hit_s) begin
      starve_cnt_r <= starve_cnt_r + SC_W'(1);
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  // Load the granted request into the slot; hold it until memory accepts
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req_valid_r <= 1'b0;
      mem_req_we_r    <= 1'b0;
      mem_req_addr_r  <= {ADDR_W{1'b0}};
      mem_req_wdata_r <= {DATA_W{1'b0}};
      mem_req_be_r    <= {BE_W{1'b0}};
    end else if (ld_grant_s) begin
      mem_req_valid_r <= 1'b1;
      mem_req_we_r    <= 1'b0;
      mem_req_addr_r  <= ld_req_addr;
      mem_req_wdata_r <= {DATA_W{1'b0}};
      mem_req_be_r    <= {BE_W{1'b1}};
    end else if (st_grant_s) begin
      mem_req_valid_r <= 1'b1;
      mem_req_we_r    <= 1'b1;
      mem_req_addr_r  <= st_req_addr;
      mem_req_wdata_r <= st_req_data;
      mem_req_be_r    <= st_req_be;
    end else if (mem_req_ready) begin
      mem_req_valid_r <= 1'b0;
    end else begin
      mem_req_valid_r <= mem_req_valid_r;
    end
  end

  // Tag FIFO pointers, occupancy, drop marks and the sticky unexpected-response flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      outst_cnt_r <= {CNT_W{1'b0}};
      err_unexp_r <= 1'b0;
      drop_r      <= {MAX_OUTST{1'b0}};
    end else begin
      if (ld_grant_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      outst_cnt_r <= outst_cnt_r + CNT_W'(ld_grant_s) - CNT_W'(pop_s);
      err_unexp_r <= err_unexp_r || (mem_resp_valid && fifo_empty_s);
      // Marking stale slots too is harmless: a push rewrites its drop bit
      if (flush) begin
        drop_r <= {MAX_OUTST{1'b1}};
      end else if (ld_grant_s) begin
        drop_r[wr_ptr_r] <= 1'b0;
      end
    end
  end

  // ROB tag storage written on each load grant
  always_ff @(posedge clk) begin
    if (ld_grant_s) begin
      rob_mem_r[wr_ptr_r] <= ld_req_rob;
    end
  end

  assign mem_req_valid  = mem_req_valid_r;
  assign mem_req_we     = mem_req_we_r;
  assign mem_req_addr   = mem_req_addr_r;
  assign mem_req_wdata  = mem_req_wdata_r;
  assign mem_req_be     = mem_req_be_r;
  // A response in a flush cycle belongs to a load that is being squashed
  assign ld_resp_valid  = pop_s && !drop_r[rd_ptr_r] && !flush;
  assign ld_resp_rob    = rob_mem_r[rd_ptr_r];
  assign ld_resp_data   = mem_resp_data;
  assign outst_cnt      = outst_cnt_r;
  assign err_unexp_resp = err_unexp_r;

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Bench for lsu_mem_arbiter: expected memory requests and load responses are
// queued as stimulus is driven and compared as the DUT produces them.
module tb_lsu_mem_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int ROB_W      = 6;
  localparam int MAX_OUTST  = 4;
  localparam int STARVE_LIM = 4;
  localparam int BE_W       = DATA_W / 8;
  localparam int REQ_W      = 1 + ADDR_W + DATA_W + BE_W;
  localparam int RSP_W      = ROB_W + DATA_W;

  logic                       clk;
  logic                       rst;
  logic                       flush;
  logic                       ld_req_valid;
  logic                       ld_req_ready;
  logic [ADDR_W-1:0]          ld_req_addr;
  logic [ROB_W-1:0]           ld_req_rob;
  logic                       st_req_valid;
  logic                       st_req_ready;
  logic [ADDR_W-1:0]          st_req_addr;
  logic [DATA_W-1:0]          st_req_data;
  logic [BE_W-1:0]            st_req_be;
  logic                       mem_req_valid;
  logic                       mem_req_ready;
  logic                       mem_req_we;
  logic [ADDR_W-1:0]          mem_req_addr;
  logic [DATA_W-1:0]          mem_req_wdata;
  logic [BE_W-1:0]            mem_req_be;
  logic                       mem_resp_valid;
  logic [DATA_W-1:0]          mem_resp_data;
  logic                       ld_resp_valid;
  logic [ROB_W-1:0]           ld_resp_rob;
  logic [DATA_W-1:0]          ld_resp_data;
  logic [$clog2(MAX_OUTST):0] outst_cnt;
  logic                       err_unexp_resp;

  int checks_r   = 0;
  int failures_r = 0;

  logic [REQ_W-1:0] exp_req_q [$];
  logic [RSP_W-1:0] exp_rsp_q [$];

  lsu_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROB_W(ROB_W),
    .MAX_OUTST(MAX_OUTST), .STARVE_LIM(STARVE_LIM)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready),
    .ld_req_addr(ld_req_addr), .ld_req_rob(ld_req_rob),
    .st_req_valid(st_req_valid), .st_req_ready(st_req_ready),
    .st_req_addr(st_req_addr), .st_req_data(st_req_data), .st_req_be(st_req_be),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_be(mem_req_be),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .ld_resp_valid(ld_resp_valid), .ld_resp_rob(ld_resp_rob),
    .ld_resp_data(ld_resp_data), .outst_cnt(outst_cnt),
    .err_unexp_resp(err_unexp_resp)
  );

  initial clk = 1'b0;
  // Free-running clock, period 10
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks_r++;
    if (act !== exp) begin
      failures_r++;
      $display("FAIL %s actual=0x%0h required=0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [REQ_W-1:0] mk_ld(input logic [ADDR_W-1:0] a);
    return {1'b0, a, {DATA_W{1'b0}}, {BE_W{1'b1}}};
  endfunction

  function automatic logic [REQ_W-1:0] mk_st(input logic [ADDR_W-1:0] a,
                                             input logic [DATA_W-1:0] d,
                                             input logic [BE_W-1:0] b);
    return {1'b1, a, d, b};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 1'b0; ld_req_valid = 1'b0; ld_req_addr = '0; ld_req_rob = '0;
    st_req_valid = 1'b0; st_req_addr = '0; st_req_data = '0; st_req_be = '0;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_data = '0;
  endtask

  // Scoreboard: every accepted memory request and every load response must match the next expectation
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req_valid && mem_req_ready) begin
        check_eq("mem_req_pending", 128'(exp_req_q.size() != 0), 128'(1));
        if (exp_req_q.size() != 0)
          check_eq("mem_req", 128'({mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be}),
                   128'(exp_req_q.pop_front()));
      end
      if (ld_resp_valid) begin
        check_eq("ld_resp_pending", 128'(exp_rsp_q.size() != 0), 128'(1));
        if (exp_rsp_q.size() != 0)
          check_eq("ld_resp", 128'({ld_resp_rob, ld_resp_data}), 128'(exp_rsp_q.pop_front()));
      end
    end
  end

  initial begin
    int n_out;
    bit exp_st;
    logic [ROB_W-1:0] rob_q [$];
    logic [ROB_W-1:0] next_rob;

    idle();
    rst = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    #3;
    check_eq("rst_mem_req_valid", 128'(mem_req_valid), 128'(0));
    check_eq("rst_mem_req_fields", 128'({mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be}), 128'(0));
    check_eq("rst_outst_cnt", 128'(outst_cnt), 128'(0));
    check_eq("rst_err", 128'(err_unexp_resp), 128'(0));
    cyc();

    // Single load with response two cycles after the request appears
    ld_req_valid = 1'b1; ld_req_addr = 32'h100; ld_req_rob = 6'd5;
    exp_req_q.push_back(mk_ld(32'h100));
    #3;
    check_eq("t1_ld_ready", 128'(ld_req_ready), 128'(1));
    check_eq("t1_st_ready", 128'(st_req_ready), 128'(0));
    check_eq("t1_no_same_cycle_req", 128'(mem_req_valid), 128'(0));
    cyc();
    ld_req_valid = 1'b0;
    #3;
    check_eq("t1_req_valid", 128'(mem_req_valid), 128'(1));
    check_eq("t1_outst_1", 128'(outst_cnt), 128'(1));
    cyc();
    #3;
    check_eq("t1_req_done", 128'(mem_req_valid), 128'(0));
    cyc();
    mem_resp_valid = 1'b1; mem_resp_data = 32'hDEAD;
    exp_rsp_q.push_back({6'd5, 32'hDEAD});
    #3;
    check_eq("t1_resp_valid", 128'(ld_resp_valid), 128'(1));
    check_eq("t1_resp_rob", 128'(ld_resp_rob), 128'(5));
    check_eq("t1_resp_data", 128'(ld_resp_data), 128'(32'hDEAD));
    cyc();
    mem_resp_valid = 1'b0;
    #3;
    check_eq("t1_outst_0", 128'(outst_cnt), 128'(0));
    cyc();

    // Continuous loads and stores: four loads then one store, repeating
    n_out = 0;
    next_rob = 6'd20;
    for (int i = 0; i < 10; i++) begin
      exp_st = ((i % 5) == 4);
      ld_req_valid = 1'b1; ld_req_addr = 32'h400 + 32'(i * 4); ld_req_rob = next_rob;
      st_req_valid = 1'b1; st_req_addr = 32'h800 + 32'(i * 4);
      st_req_data = 32'h5000 + 32'(i); st_req_be = 4'hF;
      #0;
      check_eq("t2_outst", 128'(outst_cnt), 128'(n_out));
      if (n_out > 0) begin
        mem_resp_valid = 1'b1; mem_resp_data = 32'hA000 + 32'(i);
        exp_rsp_q.push_back({rob_q.pop_front(), mem_resp_data});
        n_out--;
      end else begin
        mem_resp_valid = 1'b0;
      end
      if (exp_st) begin
        exp_req_q.push_back(mk_st(st_req_addr, st_req_data, st_req_be));
      end else begin
        exp_req_q.push_back(mk_ld(ld_req_addr));
        rob_q.push_back(next_rob);
        next_rob = next_rob + 6'd1;
        n_out++;
      end
      #3;
      check_eq("t2_ld_ready", 128'(ld_req_ready), 128'(!exp_st));
      check_eq("t2_st_ready", 128'(st_req_ready), 128'(exp_st));
      cyc();
    end
    idle();
    #3;
    check_eq("t2_outst_end", 128'(outst_cnt), 128'(0));
    cyc();

    // Fill the tag FIFO; a waiting store takes the slot; a pop is credited one cycle later
    for (int j = 0; j < 4; j++) begin
      ld_req_valid = 1'b1; ld_req_addr = 32'h600 + 32'(j * 4); ld_req_rob = 6'(10 + j);
      exp_req_q.push_back(mk_ld(ld_req_addr));
      #3;
      check_eq("t3_fill_ready", 128'(ld_req_ready), 128'(1));
      check_eq("t3_fill_outst", 128'(outst_cnt), 128'(j));
      cyc();
    end
    ld_req_addr = 32'h610; ld_req_rob = 6'd14;
    st_req_valid = 1'b1; st_req_addr = 32'h900; st_req_data = 32'h55; st_req_be = 4'hF;
    exp_req_q.push_back(mk_st(32'h900, 32'h55, 4'hF));
    #3;
    check_eq("t3_full_outst", 128'(outst_cnt), 128'(4));
    check_eq("t3_full_ld_ready", 128'(ld_req_ready), 128'(0));
    check_eq("t3_full_st_ready", 128'(st_req_ready), 128'(1));
    cyc();
    st_req_valid = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 32'hB0;
    exp_rsp_q.push_back({6'd10, 32'hB0});
    #3;
    check_eq("t3_pop_not_credited", 128'(ld_req_ready), 128'(0));
    cyc();
    mem_resp_valid = 1'b0;
    exp_req_q.push_back(mk_ld(32'h610));
    #3;
    check_eq("t3_after_pop_outst", 128'(outst_cnt), 128'(3));
    check_eq("t3_after_pop_ready", 128'(ld_req_ready), 128'(1));
    cyc();
    ld_req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mem_resp_valid = 1'b1; mem_resp_data = 32'hB1 + 32'(k);
      exp_rsp_q.push_back({6'(11 + k), mem_resp_data});
      cyc();
    end
    mem_resp_valid = 1'b0;
    #3;
    check_eq("t3_drained", 128'(outst_cnt), 128'(0));
    cyc();

    // Backpressure: load held in the slot for 3 cycles while a store waits
    ld_req_valid = 1'b1; ld_req_addr = 32'h140; ld_req_rob = 6'd7;
    exp_req_q.push_back(mk_ld(32'h140));
    #3;
    check_eq("t4_ld_ready", 128'(ld_req_ready), 128'(1));
    cyc();
    ld_req_valid = 1'b0; mem_req_ready = 1'b0;
    st_req_valid = 1'b1; st_req_addr = 32'h200; st_req_data = 32'h1234; st_req_be = 4'h3;
    for (int k = 0; k < 3; k++) begin
      #3;
      check_eq("t4_hold_valid", 128'(mem_req_valid), 128'(1));
      check_eq("t4_hold_req", 128'({mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be}),
               128'(mk_ld(32'h140)));
      check_eq("t4_hold_st_ready", 128'(st_req_ready), 128'(0));
      check_eq("t4_hold_ld_ready", 128'(ld_req_ready), 128'(0));
      cyc();
    end
    mem_req_ready = 1'b1;
    exp_req_q.push_back(mk_st(32'h200, 32'h1234, 4'h3));
    #3;
    check_eq("t4_release_st_ready", 128'(st_req_ready), 128'(1));
    cyc();
    st_req_valid = 1'b0;
    #3;
    check_eq("t4_store_out", 128'({mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be}),
             128'({1'b1, mk_st(32'h200, 32'h1234, 4'h3)}));
    cyc();
    mem_resp_valid = 1'b1; mem_resp_data = 32'h77;
    exp_rsp_q.push_back({6'd7, 32'h77});
    cyc();
    mem_resp_valid = 1'b0;
    cyc();

    // Flush with three loads in flight: their responses vanish, a fourth is unexpected
    for (int j = 0; j < 3; j++) begin
      ld_req_valid = 1'b1; ld_req_addr = 32'h700 + 32'(j * 4); ld_req_rob = 6'(1 + j);
      exp_req_q.push_back(mk_ld(ld_req_addr));
      cyc();
    end
    ld_req_addr = 32'h70C; ld_req_rob = 6'd4; flush = 1'b1;
    #3;
    check_eq("t5_flush_no_ld_grant", 128'(ld_req_ready), 128'(0));
    check_eq("t5_flush_outst", 128'(outst_cnt), 128'(3));
    cyc();
    flush = 1'b0; ld_req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mem_resp_valid = 1'b1; mem_resp_data = 32'hC0 + 32'(k);
      #3;
      check_eq("t5_dropped", 128'(ld_resp_valid), 128'(0));
      cyc();
    end
    mem_resp_valid = 1'b0;
    #3;
    check_eq("t5_empty", 128'(outst_cnt), 128'(0));
    check_eq("t5_no_err", 128'(err_unexp_resp), 128'(0));
    cyc();
    mem_resp_valid = 1'b1; mem_resp_data = 32'hEE;
    #3;
    check_eq("t5_unexp_no_resp", 128'(ld_resp_valid), 128'(0));
    cyc();
    mem_resp_valid = 1'b0;
    #3;
    check_eq("t5_err_set", 128'(err_unexp_resp), 128'(1));
    check_eq("t5_outst_stays_0", 128'(outst_cnt), 128'(0));
    cyc();
    #3;
    check_eq("t5_err_sticky", 128'(err_unexp_resp), 128'(1));
    cyc();

    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    #3;
    check_eq("t5_rst_err", 128'(err_unexp_resp), 128'(0));
    cyc();

    // Load and store to the same word with an idle starvation counter
    ld_req_valid = 1'b1; ld_req_addr = 32'h300; ld_req_rob = 6'd9;
    st_req_valid = 1'b1; st_req_addr = 32'h300; st_req_data = 32'hCAFE; st_req_be = 4'hF;
`ifdef LSU_RAW_ORDER_EN
    exp_req_q.push_back(mk_st(32'h300, 32'hCAFE, 4'hF));
    #3;
    check_eq("t6_raw_st_first", 128'({st_req_ready, ld_req_ready}), 128'(2'b10));
    cyc();
    st_req_valid = 1'b0;
    exp_req_q.push_back(mk_ld(32'h300));
    #3;
    check_eq("t6_raw_ld_next", 128'({st_req_ready, ld_req_ready}), 128'(2'b01));
    cyc();
`else
    exp_req_q.push_back(mk_ld(32'h300));
    #3;
    check_eq("t6_ld_first", 128'({st_req_ready, ld_req_ready}), 128'(2'b01));
    cyc();
    ld_req_valid = 1'b0;
    exp_req_q.push_back(mk_st(32'h300, 32'hCAFE, 4'hF));
    #3;
    check_eq("t6_st_next", 128'({st_req_ready, ld_req_ready}), 128'(2'b10));
    cyc();
`endif
    idle();
    cyc();
    mem_resp_valid = 1'b1; mem_resp_data = 32'h99;
    exp_rsp_q.push_back({6'd9, 32'h99});
    cyc();
    mem_resp_valid = 1'b0;
    repeat (3) cyc();

    check_eq("end_req_q_empty", 128'(exp_req_q.size()), 128'(0));
    check_eq("end_rsp_q_empty", 128'(exp_rsp_q.size()), 128'(0));
    check_eq("end_outst", 128'(outst_cnt), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
    $finish;
  end

endmodule
